xy_rr_out_arbiter: RTL and testbench
====================================

XY_RR_OUT_ARBITER -- requirements
Module: xy_rr_out_arbiter

Interface
REQ-001 SHALL have parameter PORT_N, default 5, number of switch input ports competing for this output port.
REQ-002 SHALL have parameter PCKT_W, default 16, packet width (4b X addr + 4b Y addr + 8b data).
REQ-003 SHALL have parameter STALL_CNT_W, default 8, width of the stall counter.
REQ-004 SHALL have port clk_i, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port req_i, input, PORT_N, bit i high = input FIFO i non-empty and its head packet is routed to this output.
REQ-007 SHALL have port pckt_i, input, PCKT_W*PORT_N, head packets; slice i = bits [PCKT_W*i +: PCKT_W].
REQ-008 SHALL have port nxt_fifo_full_i, input, 1, next-hop input FIFO full.
REQ-009 SHALL have port rd_en_o, output, PORT_N, one-hot-or-zero pop strobe to input FIFOs.
REQ-010 SHALL have port wr_en_o, output, 1, write strobe to the next-hop FIFO.
REQ-011 SHALL have port pckt_o, output, PCKT_W, registered packet to the next hop.
REQ-012 SHALL have port last_grant_o, output, PORT_N, one-hot index of the most recent grant.
REQ-013 SHALL have port stall_cnt_o, output, STALL_CNT_W, count of stall cycles.

Function
REQ-014 Grant condition SHALL be: |req_i == 1 and nxt_fifo_full_i == 0.
REQ-015 When the grant condition holds, the block SHALL select exactly one requester: the first set bit of req_i searching circularly from index ptr upward (ptr, ptr+1, ..., PORT_N-1, 0, ..., ptr-1).
REQ-016 rd_en_o SHALL be combinational, same cycle as the decision: one-hot at the granted index, zero when there is no grant.
REQ-017 On a grant at index g, the block SHALL, at the next edge, load pckt_o with slice g of pckt_i and drive wr_en_o = 1 for exactly that one cycle (latency 1).
REQ-018 Without a grant, wr_en_o SHALL be 0 on the next cycle and pckt_o SHALL hold its value.
REQ-019 On a grant at g, the pointer SHALL update to ptr <= (g == PORT_N-1) ? 0 : g+1, and last_grant_o SHALL be set to one-hot g.
REQ-020 Without a grant, ptr and last_grant_o SHALL hold.
REQ-021 Back-to-back grants SHALL be allowed on consecutive cycles, giving up to 1 packet per cycle.
REQ-022 Fairness: with N continuous requesters, each SHALL be granted once in every N consecutive grants.
REQ-023 Arbitration SHALL be realised as an FSM with two states:
- IDLE: no request.
- STALL: |req_i == 1 and nxt_fifo_full_i == 1.
- A grant cycle is IDLE with the grant condition met.
- State is registered from the current cycle's inputs.
REQ-024 stall_cnt_o SHALL increment by 1 on each cycle where |req_i == 1 and nxt_fifo_full_i == 1, and SHALL saturate at all-ones (no wrap).
REQ-025 nxt_fifo_full_i SHALL have priority: a request in the same cycle as full SHALL receive no grant, rd_en_o = 0.
REQ-026 The block SHALL be purely a function of the current req_i and ptr; it SHALL NOT make any assumption about whether a request is held.

Reset
REQ-027 While rst_i == 1 at an edge, the block SHALL set:
- ptr = 0, last_grant_o = 0, pckt_o = 0, wr_en_o = 0, stall_cnt_o = 0, FSM = IDLE.
REQ-028 While rst_i == 1, rd_en_o SHALL be forced to 0 regardless of req_i.
REQ-029 Reset asserted mid-stream SHALL discard any in-flight grant: wr_en_o = 0 on the cycle after the reset edge, and no pop is issued.

Verification
REQ-030 Reset, then req_i = 5'b00000 for 5 cycles -> rd_en_o = 0, wr_en_o = 0, stall_cnt_o = 0.
REQ-031 req_i = 5'b11111 held for 10 cycles, full = 0 -> grant order 0,1,2,3,4,0,1,2,3,4; wr_en_o = 1 every cycle from cycle 2; pckt_o matches each granted slice one cycle later.
REQ-032 req_i = 5'b10100, ptr = 3 -> first grant 4, then 2, then 4.
REQ-033 req_i = 5'b00010, nxt_fifo_full_i = 1 for 300 cycles -> rd_en_o = 0 and wr_en_o = 0 throughout; stall_cnt_o saturates at 255; on full deassert, grant 1 and pckt_o = pckt_i[31:16] next cycle.
REQ-034 rst_i pulsed in the cycle after a grant to port 2 -> wr_en_o = 0 the next cycle, ptr = 0, and the next grant with req_i = 5'b11111 goes to 0.
REQ-035 Random req_i/full over 10k cycles -> rd_en_o always one-hot-or-zero; pops equal wr_en_o pulses; no requester waits more than PORT_N grants.

Source files
------------

// File: rtl/xy_rr_out_arbiter.sv
// Round-robin output-port arbiter for an XY-routed mesh switch: picks one input FIFO
// per cycle, pops it, and forwards its head packet to the next hop one cycle later.
module xy_rr_out_arbiter #(
  parameter int PORT_N      = 5,
  parameter int PCKT_W      = 16,
  parameter int STALL_CNT_W = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [PORT_N-1:0]        req_i,
  input  logic [PCKT_W*PORT_N-1:0] pckt_i,
  input  logic                     nxt_fifo_full_i,
  output logic [PORT_N-1:0]        rd_en_o,
  output logic                     wr_en_o,
  output logic [PCKT_W-1:0]        pckt_o,
  output logic [PORT_N-1:0]        last_grant_o,
  output logic [STALL_CNT_W-1:0]   stall_cnt_o
);

  localparam int PTR_W = (PORT_N > 1) ? $clog2(PORT_N) : 1;

  typedef enum logic {IDLE, STALL} state_t;

  state_t                   state_q, state_d;
  logic [PTR_W-1:0]         ptr_q;
  logic [PTR_W-1:0]         grant_idx_p0;
  logic                     found_p0;
  logic                     stall_p0;
  logic                     vld_p0;
  logic [PCKT_W-1:0]        pckt_p0;
  logic [PORT_N-1:0]        onehot_p0;

  logic                     vld_p1;
  logic [PCKT_W-1:0]        pckt_p1;
  logic [PORT_N-1:0]        last_grant_p1;
  logic [STALL_CNT_W-1:0]   stall_cnt_p1;

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Stage p0: circular first-set search starting at ptr, purely from current inputs
  always_comb begin
    logic [PTR_W:0] sum;
    sum          = '0;
    grant_idx_p0 = '0;
    found_p0     = 1'b0;
    for (int k = 0; k < PORT_N; k++) begin
      sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(PORT_N)) sum = sum - (PTR_W+1)'(PORT_N);
      if (!found_p0 && req_i[sum[PTR_W-1:0]]) begin
        found_p0     = 1'b1;
        grant_idx_p0 = sum[PTR_W-1:0];
      end
    end
  end

  assign stall_p0  = (|req_i) && nxt_fifo_full_i;
  assign vld_p0    = found_p0 && !nxt_fifo_full_i && !rst_i;
  assign onehot_p0 = PORT_N'(1) << grant_idx_p0;
  assign pckt_p0   = pckt_i[int'(grant_idx_p0)*PCKT_W +: PCKT_W];
  assign rd_en_o   = vld_p0 ? onehot_p0 : '0;

  // Leaving STALL is immediate: the grant on release comes from the inputs, not the state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (stall_p0)  state_d = STALL;
      STALL:   if (!stall_p0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p1: registered packet, write strobe and arbitration state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      vld_p1        <= 1'b0;
      pckt_p1       <= '0;
      last_grant_p1 <= '0;
      stall_cnt_p1  <= '0;
    end else begin
      state_q <= state_d;
      vld_p1  <= vld_p0;
      if (vld_p0) begin
        pckt_p1       <= pckt_p0;
        last_grant_p1 <= onehot_p0;
        ptr_q         <= (grant_idx_p0 == PTR_W'(PORT_N-1)) ? '0 : grant_idx_p0 + PTR_W'(1);
      end
      if (stall_p0) stall_cnt_p1 <= sat_inc(stall_cnt_p1);
    end
  end

  assign wr_en_o      = vld_p1;
  assign pckt_o       = pckt_p1;
  assign last_grant_o = last_grant_p1;
  assign stall_cnt_o  = stall_cnt_p1;

endmodule

// File: tb/tb_xy_rr_out_arbiter.sv
// Randomized and directed bench for xy_rr_out_arbiter against a behavioural
// round-robin model (pointer, last grant, packet, stall counter).
module tb_xy_rr_out_arbiter;

  localparam int N  = 5;
  localparam int W  = 16;
  localparam int CW = 8;

  logic           clk = 1'b0;
  logic           rst_i = 1'b1;
  logic [N-1:0]   req_i = '0;
  logic [W*N-1:0] pckt_i = '0;
  logic           nxt_fifo_full_i = 1'b0;
  logic [N-1:0]   rd_en_o;
  logic           wr_en_o;
  logic [W-1:0]   pckt_o;
  logic [N-1:0]   last_grant_o;
  logic [CW-1:0]  stall_cnt_o;

  always #5 clk = ~clk;

  xy_rr_out_arbiter #(.PORT_N(N), .PCKT_W(W), .STALL_CNT_W(CW)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .req_i          (req_i),
    .pckt_i         (pckt_i),
    .nxt_fifo_full_i(nxt_fifo_full_i),
    .rd_en_o        (rd_en_o),
    .wr_en_o        (wr_en_o),
    .pckt_o         (pckt_o),
    .last_grant_o   (last_grant_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  int checks = 0;
  int errors = 0;

  int           m_ptr  = 0;
  int           m_last = 0;
  logic [W-1:0] m_pckt = '0;
  int           m_wr   = 0;
  int           m_cnt  = 0;
  int           waits[N];
  int           pops   = 0;
  int           pulses = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input int p, input logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic cycle(input logic [N-1:0] req, input logic full, input logic rst);
    int           g;
    logic         gv;
    logic [W-1:0] slice;
    @(negedge clk);
    req_i = req;
    nxt_fifo_full_i = full;
    rst_i = rst;
    for (int i = 0; i < N; i++) pckt_i[i*W +: W] = W'($urandom);
    #1;
    g  = rr_pick(m_ptr, req);
    gv = !rst && !full && (g >= 0);
    slice = gv ? pckt_i[g*W +: W] : '0;
    chk("rd_en", 32'(rd_en_o), gv ? (32'd1 << g) : 32'd0);
    chk("rd_onehot", 32'($countones(rd_en_o) <= 1), 32'd1);
    if (rd_en_o != '0) begin
      pops++;
      for (int i = 0; i < N; i++) begin
        if (rd_en_o[i] || !req[i]) waits[i] = 0;
        else begin
          waits[i]++;
          chk("wait_bound", 32'(waits[i] < N), 32'd1);
        end
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      m_ptr = 0; m_last = 0; m_pckt = '0; m_wr = 0; m_cnt = 0;
      for (int i = 0; i < N; i++) waits[i] = 0;
    end else begin
      m_wr = gv ? 1 : 0;
      if (gv) begin
        m_pckt = slice;
        m_ptr  = (g == N-1) ? 0 : g + 1;
        m_last = 1 << g;
      end
      if (req != '0 && full && m_cnt < (1 << CW) - 1) m_cnt++;
    end
    if (wr_en_o) pulses++;
    chk("wr_en", 32'(wr_en_o), 32'(m_wr));
    chk("pckt_o", 32'(pckt_o), 32'(m_pckt));
    chk("last_grant", 32'(last_grant_o), 32'(m_last));
    chk("stall_cnt", 32'(stall_cnt_o), 32'(m_cnt));
  endtask

  initial begin
    for (int i = 0; i < N; i++) waits[i] = 0;
    cycle('0, 1'b0, 1'b1);
    cycle('0, 1'b0, 1'b1);

    // idle after reset
    for (int i = 0; i < 5; i++) cycle(5'b00000, 1'b0, 1'b0);
    chk("idle_wr", 32'(wr_en_o), 32'd0);
    chk("idle_cnt", 32'(stall_cnt_o), 32'd0);

    // all requesting: strict rotation 0..4
    for (int i = 0; i < 10; i++) begin
      cycle(5'b11111, 1'b0, 1'b0);
      chk("rotate_order", 32'(last_grant_o), 32'd1 << (i % N));
      chk("rotate_wr", 32'(wr_en_o), 32'd1);
    end

    // pointer at 3, sparse requesters 4 and 2
    cycle(5'b00100, 1'b0, 1'b0);
    cycle(5'b10100, 1'b0, 1'b0);
    chk("skip_1st", 32'(last_grant_o), 32'b10000);
    cycle(5'b10100, 1'b0, 1'b0);
    chk("skip_2nd", 32'(last_grant_o), 32'b00100);
    cycle(5'b10100, 1'b0, 1'b0);
    chk("skip_3rd", 32'(last_grant_o), 32'b10000);

    // long stall saturates the counter; release grants port 1
    for (int i = 0; i < 300; i++) cycle(5'b00010, 1'b1, 1'b0);
    chk("stall_sat", 32'(stall_cnt_o), 32'd255);
    chk("stall_wr", 32'(wr_en_o), 32'd0);
    cycle(5'b00010, 1'b0, 1'b0);
    chk("release_grant", 32'(last_grant_o), 32'b00010);
    chk("release_pckt", 32'(pckt_o), 32'(pckt_i[31:16]));
    chk("release_wr", 32'(wr_en_o), 32'd1);

    // reset right after a grant to port 2 discards it
    cycle(5'b00100, 1'b0, 1'b0);
    chk("pre_rst_wr", 32'(wr_en_o), 32'd1);
    cycle(5'b11111, 1'b0, 1'b1);
    chk("rst_wr", 32'(wr_en_o), 32'd0);
    chk("rst_last", 32'(last_grant_o), 32'd0);
    cycle(5'b11111, 1'b0, 1'b0);
    chk("post_rst_grant", 32'(last_grant_o), 32'b00001);

    // random traffic
    cycle(5'b00000, 1'b0, 1'b0);
    pops = 0;
    pulses = 0;
    for (int i = 0; i < 10000; i++)
      cycle(N'($urandom_range(0, 31)), ($urandom_range(0, 3) == 0), 1'b0);
    cycle(5'b00000, 1'b0, 1'b0);
    chk("pops_vs_wr", 32'(pulses), 32'(pops));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
